// File: rtl/diff_demo_pkg.sv
// Shared types and sizes for the PE psum collector.
// Lane geometry is fixed by the PE array (3 rows x 6 cols).
package diff_demo_pkg;

  localparam int PSUM_WIDTH = 24;
  localparam int ACC_WIDTH  = 32;
  localparam int PSUM_LANES = 18;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_FETCH,
    PC_CAPT,
    PC_EMIT
  } psum_col_state_t;

  typedef logic [PSUM_LANES-1:0][ACC_WIDTH-1:0] psum_acc_t;

endpackage

// File: rtl/psum_collector_if.sv
// Serial activation stream: valid/ready with a last-lane flag.
// The collector drives it as master, the consumer as slave.
interface psum_collector_if;

  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/psum_requant.sv
// Bias add, optional ReLU, round-half-up shift and int8 saturation.
// Purely combinational; one instance serves all lanes via a mux.
module psum_requant #(
  parameter int ACC_WIDTH = 32
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic signed [ACC_WIDTH-1:0] bias_i,
  input  logic        [4:0]           shift_i,
  input  logic                        relu_i,
  output logic        [7:0]           out_o
);
  import diff_demo_pkg::*;

  // Two guard bits: one for the bias add, one for the rounding add.
  localparam int SW = ACC_WIDTH + 2;
  localparam logic signed [SW-1:0] MAXV = 127;
  localparam logic signed [SW-1:0] MINV = -128;

  logic signed [SW-1:0] s;
  logic signed [SW-1:0] r;
  logic signed [SW-1:0] q;

  always_comb begin
    s = SW'(acc_i) + SW'(bias_i);
    if (relu_i && s[SW-1]) begin
      s = '0;
    end
    r = s;
    if (shift_i != 5'd0) begin
      r = s + (SW'(1) << (shift_i - 5'd1));
    end
    q = r >>> shift_i;
    if (q > MAXV) begin
      out_o = 8'h7F;
    end else if (q < MINV) begin
      out_o = 8'h80;
    end else begin
      out_o = q[7:0];
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Drains the PE psum FIFO, accumulates over channels and
// streams 18 requantized int8 activations per tile.
module psum_collector #(
  parameter int PSUM_WIDTH = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic [7:0]                  cfg_num_ch,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_relu,
  input  logic [ACC_WIDTH-1:0]        bias_i,
  input  logic                        fifo_empty_i,
  output logic                        fifo_rd_en_o,
  input  logic [LANES*PSUM_WIDTH-1:0] fifo_dout_i,
  psum_collector_if.master            out_if,
  output logic                        busy_o,
  output logic                        done_o
);
  import diff_demo_pkg::*;

  typedef logic [LANES-1:0][ACC_WIDTH-1:0] acc_t;

  localparam logic [4:0] LAST_LANE = 5'(LANES - 1);

  psum_col_state_t      state_q;
  acc_t                 acc_q;
  acc_t                 acc_d;
  logic [7:0]           ch_cnt_q;
  logic [7:0]           num_ch_q;
  logic [4:0]           shift_q;
  logic                 relu_q;
  logic [ACC_WIDTH-1:0] bias_q;
  logic [4:0]           lane_q;
  logic                 done_q;

  logic [7:0] rq_data;
  logic       emit;
  logic       hs;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      acc_d[k] = acc_q[k] + ACC_WIDTH'(signed'(
        fifo_dout_i[k*PSUM_WIDTH +: PSUM_WIDTH]));
    end
  end

  psum_requant #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_requant (
    .acc_i   (acc_q[lane_q]),
    .bias_i  (bias_q),
    .shift_i (shift_q),
    .relu_i  (relu_q),
    .out_o   (rq_data)
  );

  assign emit = (state_q == PC_EMIT);
  assign hs   = emit && out_if.ready;

  assign out_if.valid = emit;
  assign out_if.data  = emit ? rq_data : 8'h00;
  assign out_if.last  = emit && (lane_q == LAST_LANE);

  assign fifo_rd_en_o = (state_q == PC_FETCH)
                      && !fifo_empty_i && !rst;
  assign busy_o = (state_q != PC_IDLE);
  assign done_o = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PC_IDLE;
      acc_q    <= '0;
      ch_cnt_q <= '0;
      num_ch_q <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      bias_q   <= '0;
      lane_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        PC_IDLE: begin
          if (cfg_start) begin
            num_ch_q <= (cfg_num_ch == 8'd0) ? 8'd1 : cfg_num_ch;
            shift_q  <= cfg_shift;
            relu_q   <= cfg_relu;
            bias_q   <= bias_i;
            acc_q    <= '0;
            ch_cnt_q <= '0;
            lane_q   <= '0;
            state_q  <= PC_FETCH;
          end
        end
        PC_FETCH: begin
          if (fifo_rd_en_o) begin
            state_q <= PC_CAPT;
          end
        end
        PC_CAPT: begin
          acc_q    <= acc_d;
          ch_cnt_q <= ch_cnt_q + 8'd1;
          if (({1'b0, ch_cnt_q} + 9'd1) < {1'b0, num_ch_q}) begin
            state_q <= PC_FETCH;
          end else begin
            lane_q  <= '0;
            state_q <= PC_EMIT;
          end
        end
        PC_EMIT: begin
          if (hs) begin
            if (lane_q == LAST_LANE) begin
              state_q <= PC_IDLE;
              done_q  <= 1'b1;
            end else begin
              lane_q <= lane_q + 5'd1;
            end
          end
        end
        default: state_q <= PC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Directed self-checking bench for psum_collector.
// A queue models the PE FIFO with one-cycle read latency.
`timescale 1ns/100ps
module tb_psum_collector;

  localparam int PW = 24;
  localparam int L  = 18;
  localparam int WW = PW * L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [7:0]    cfg_num_ch = '0;
  logic [4:0]    cfg_shift = '0;
  logic          cfg_relu = 1'b0;
  logic [31:0]   bias = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [WW-1:0] fifo_dout = '0;
  logic          busy_o;
  logic          done_o;

  psum_collector_if oif();

  psum_collector dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_num_ch   (cfg_num_ch),
    .cfg_shift    (cfg_shift),
    .cfg_relu     (cfg_relu),
    .bias_i       (bias),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_dout_i  (fifo_dout),
    .out_if       (oif),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            rd_cnt = 0;
  bit            hold_empty = 1'b0;
  logic          rd_seen = 1'b0;
  logic [WW-1:0] fq[$];
  logic [7:0]    got_d[L];
  logic          got_l[L];
  int            n_got;

  initial begin
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      fifo_empty = hold_empty || (fq.size() == 0);
      #1;
      rd_seen = fifo_rd_en;
      if (fifo_rd_en) begin
        n_cmp++;
        if (fifo_empty) begin
          n_bad++;
          $display("FAIL rd_while_empty: rd_en=1 empty=%0b want no read",
                   fifo_empty);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rd_seen) begin
      fifo_dout <= fq.pop_front();
      rd_cnt++;
    end
  end

  function automatic logic [WW-1:0] fill(input int v);
    logic [WW-1:0] w;
    for (int k = 0; k < L; k++) w[k*PW +: PW] = PW'(v);
    return w;
  endfunction

  task automatic start_tile(input int nch, input int sh,
                            input bit rl, input int b);
    @(negedge clk);
    cfg_num_ch = 8'(nch);
    cfg_shift  = 5'(sh);
    cfg_relu   = rl;
    bias       = b;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
  endtask

  task automatic collect(input bit rnd);
    bit         stalled;
    logic [7:0] pd;
    logic       pl;
    int         cyc;
    n_got = 0;
    stalled = 0;
    cyc = 0;
    pd = '0;
    pl = 1'b0;
    for (int i = 0; i < L; i++) begin
      got_d[i] = 'x;
      got_l[i] = 'x;
    end
    while (n_got < L && cyc < 3000) begin
      @(negedge clk);
      oif.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      cyc++;
      if (stalled) begin
        n_cmp++;
        if (oif.valid !== 1'b1 || oif.data !== pd || oif.last !== pl) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                   oif.valid, oif.data, oif.last, pd, pl);
        end
      end
      if (oif.valid === 1'b1 && oif.ready) begin
        got_d[n_got] = oif.data;
        got_l[n_got] = oif.last;
        n_got++;
      end
      stalled = (oif.valid === 1'b1) && !oif.ready;
      pd = oif.data;
      pl = oif.last;
    end
    n_cmp++;
    if (n_got != L) begin
      n_bad++;
      $display("FAIL collect_count: got %0d lanes want %0d", n_got, L);
    end
    @(negedge clk);
    oif.ready = 1'b0;
    #2;
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: got done=%0b busy=%0b want done=1 busy=0",
               done_o, busy_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (oif.valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %0b want 0", oif.valid);
    end
    n_cmp++;
    if (oif.data !== 8'h00) begin
      n_bad++; $display("FAIL rst_data: got %0h want 0", oif.data);
    end
    n_cmp++;
    if (oif.last !== 1'b0) begin
      n_bad++; $display("FAIL rst_last: got %0b want 0", oif.last);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %0b want 0", busy_o);
    end
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_done: got %0b want 0", done_o);
    end
    n_cmp++;
    if (fifo_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_rd_en: got %0b want 0", fifo_rd_en);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [WW-1:0] w;
    int b0;
    for (int k = 0; k < L; k++) w[k*PW +: PW] = PW'(k - 9);
    fq.push_back(w);
    b0 = rd_cnt;
    start_tile(1, 0, 0, 0);
    collect(0);
    for (int i = 0; i < L; i++) begin
      n_cmp++;
      if (got_d[i] !== 8'(i - 9) || got_l[i] !== (i == L - 1)) begin
        n_bad++;
        $display("FAIL basic_lane%0d: got d=%0d l=%0b want d=%0d l=%0b",
                 i, $signed(got_d[i]), got_l[i], i - 9, i == L - 1);
      end
    end
    n_cmp++;
    if (rd_cnt - b0 != 1) begin
      n_bad++; $display("FAIL basic_reads: got %0d want 1", rd_cnt - b0);
    end
  endtask

  task automatic test_multi_ch();
    int b0;
    repeat (3) fq.push_back(fill(5));
    b0 = rd_cnt;
    start_tile(3, 2, 0, 0);
    collect(0);
    for (int i = 0; i < L; i++) begin
      n_cmp++;
      if (got_d[i] !== 8'd4) begin
        n_bad++;
        $display("FAIL multi_lane%0d: got %0d want 4", i, $signed(got_d[i]));
      end
    end
    n_cmp++;
    if (rd_cnt - b0 != 3) begin
      n_bad++; $display("FAIL multi_reads: got %0d want 3", rd_cnt - b0);
    end
  endtask

  task automatic test_sat_relu();
    logic [WW-1:0] w;
    bit rl[3] = '{1'b0, 1'b1, 1'b1};
    int bs[3] = '{0, 0, -2000};
    int e0[3] = '{127, 127, 0};
    int e1[3] = '{-128, 0, 0};
    for (int c = 0; c < 3; c++) begin
      w = fill(0);
      w[0 +: PW]  = PW'(1000);
      w[PW +: PW] = PW'(-1000);
      fq.push_back(w);
      start_tile(1, 0, rl[c], bs[c]);
      collect(0);
      n_cmp++;
      if (got_d[0] !== 8'(e0[c]) || got_d[1] !== 8'(e1[c])) begin
        n_bad++;
        $display("FAIL sat_case%0d: got %0d,%0d want %0d,%0d", c,
                 $signed(got_d[0]), $signed(got_d[1]), e0[c], e1[c]);
      end
      n_cmp++;
      if (got_d[L-1] !== 8'd0 || got_l[L-1] !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_tail%0d: got d=%0d l=%0b want d=0 l=1", c,
                 $signed(got_d[L-1]), got_l[L-1]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [WW-1:0] w;
    int b0;
    int t;
    for (int k = 0; k < L; k++) w[k*PW +: PW] = PW'(k);
    fq.push_back(w);
    b0 = rd_cnt;
    start_tile(3, 0, 0, 0);
    t = 0;
    while (rd_cnt == b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (rd_cnt != b0 + 1) begin
      n_bad++; $display("FAIL bp_first_read: got %0d want 1", rd_cnt - b0);
    end
    hold_empty = 1'b1;
    fq.push_back(fill(1));
    fq.push_back(fill(-2));
    repeat (5) @(negedge clk);
    #2;
    n_cmp++;
    if (rd_cnt != b0 + 1 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_empty_hold: got reads=%0d busy=%0b want 1 1",
               rd_cnt - b0, busy_o);
    end
    hold_empty = 1'b0;
    collect(1);
    for (int i = 0; i < L; i++) begin
      n_cmp++;
      if (got_d[i] !== 8'(i - 1) || got_l[i] !== (i == L - 1)) begin
        n_bad++;
        $display("FAIL bp_lane%0d: got d=%0d l=%0b want d=%0d l=%0b",
                 i, $signed(got_d[i]), got_l[i], i - 1, i == L - 1);
      end
    end
    n_cmp++;
    if (rd_cnt - b0 != 3) begin
      n_bad++; $display("FAIL bp_reads: got %0d want 3", rd_cnt - b0);
    end
  endtask

  task automatic test_start_ignored();
    int b0;
    int t;
    fq.push_back(fill(6));
    b0 = rd_cnt;
    start_tile(1, 1, 0, 0);
    t = 0;
    while (oif.valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    @(negedge clk);
    cfg_start  = 1'b1;
    cfg_shift  = 5'd0;
    cfg_num_ch = 8'd4;
    bias       = 32'd100;
    @(negedge clk);
    cfg_start  = 1'b0;
    collect(0);
    for (int i = 0; i < L; i++) begin
      n_cmp++;
      if (got_d[i] !== 8'd3) begin
        n_bad++;
        $display("FAIL ign_lane%0d: got %0d want 3", i, $signed(got_d[i]));
      end
    end
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if (busy_o !== 1'b0 || rd_cnt - b0 != 1) begin
      n_bad++;
      $display("FAIL ign_restart: got busy=%0b reads=%0d want 0 1",
               busy_o, rd_cnt - b0);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    int t;
    fq.push_back(fill(10));
    fq.push_back(fill(10));
    b0 = rd_cnt;
    start_tile(3, 0, 0, 0);
    t = 0;
    while (rd_cnt < b0 + 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (rd_cnt != b0 + 2) begin
      n_bad++; $display("FAIL rmid_reads: got %0d want 2", rd_cnt - b0);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0 || fifo_rd_en !== 1'b0 || oif.valid !== 1'b0 ||
        oif.data !== 8'h00 || oif.last !== 1'b0 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_outputs: got b=%0b r=%0b v=%0b d=%0h l=%0b dn=%0b want all 0",
               busy_o, fifo_rd_en, oif.valid, oif.data, oif.last, done_o);
    end
    @(negedge clk);
    rst = 1'b0;
    fq.delete();
    fq.push_back(fill(7));
    start_tile(1, 0, 0, 0);
    collect(0);
    for (int i = 0; i < L; i++) begin
      n_cmp++;
      if (got_d[i] !== 8'd7) begin
        n_bad++;
        $display("FAIL rmid_lane%0d: got %0d want 7", i, $signed(got_d[i]));
      end
    end
  endtask

  task automatic test_zero_ch();
    logic [WW-1:0] w;
    int exp_v[L];
    int b0;
    w = fill(0);
    w[0*PW +: PW] = PW'(-6);
    w[1*PW +: PW] = PW'(-5);
    w[2*PW +: PW] = PW'(6);
    w[3*PW +: PW] = PW'(-7);
    foreach (exp_v[i]) exp_v[i] = 0;
    exp_v[0] = -1;
    exp_v[1] = -1;
    exp_v[2] = 2;
    exp_v[3] = -2;
    fq.push_back(w);
    fq.push_back(fill(50));
    b0 = rd_cnt;
    start_tile(0, 2, 0, 0);
    collect(0);
    for (int i = 0; i < L; i++) begin
      n_cmp++;
      if (got_d[i] !== 8'(exp_v[i])) begin
        n_bad++;
        $display("FAIL zero_lane%0d: got %0d want %0d",
                 i, $signed(got_d[i]), exp_v[i]);
      end
    end
    n_cmp++;
    if (rd_cnt - b0 != 1 || fq.size() != 1) begin
      n_bad++;
      $display("FAIL zero_reads: got reads=%0d left=%0d want 1 1",
               rd_cnt - b0, fq.size());
    end
    fq.delete();
  endtask

  initial begin
    oif.ready = 1'b0;
    test_reset();
    test_basic();
    test_multi_ch();
    test_sat_relu();
    test_back_pressure();
    test_start_ignored();
    test_reset_mid();
    test_zero_ch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
